hazard3_aclint_mtimer: RTL and testbench
========================================

HAZARD3_ACLINT_MTIMER -- requirements
Module: hazard3_aclint_mtimer

Interface
REQ-001 The block SHALL have parameter N_HARTS, default 1, number of per-hart comparators and IRQ outputs (legal 1..16).
REQ-002 The block SHALL have parameter DIV_W, default 8, width of the tick prescaler divisor (legal 1..16).
REQ-003 The block SHALL have port clk  input  1  sole clock.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports paddr input 16, psel input 1, penable input 1, pwrite input 1, pwdata input 32: APB slave request.
REQ-006 The block SHALL have ports prdata output 32, pready output 1, pslverr output 1: APB slave response.
REQ-007 The block SHALL have port dbg_halt  input  1  when high, mtime and prescaler freeze.
REQ-008 The block SHALL have port tick  input  1  level, synchronous to clk; each clk edge with tick=1 is one tick event.
REQ-009 The block SHALL have port timer_irq  output N_HARTS  registered per-hart machine timer interrupt.

Function
REQ-010 The block SHALL map registers as: 0x000 CTRL (bit0 EN, bits[8+DIV_W-1:8] DIV), 0x004 IRQ_STATUS (read-only, bits[N_HARTS-1:0] = timer_irq), 0x008 MTIME, 0x00C MTIMEH, 0x100+8*i MTIMECMP[i], 0x104+8*i MTIMECMPH[i] for i < N_HARTS.
REQ-011 The block SHALL drive pready=1 always; every access completes in the APB access phase (psel && penable).
REQ-012 The block SHALL drive pslverr=1 during the access phase for any paddr not in REQ-010 (including comparator slots i >= N_HARTS and writes to IRQ_STATUS), and 0 otherwise; such writes are ignored and prdata=0.
REQ-013 The block SHALL return prdata combinationally from paddr; unimplemented CTRL bits read 0.
REQ-014 The block SHALL keep an internal DIV_W-bit prescale counter; on a cycle with tick && EN && !dbg_halt: if counter==DIV, counter<=0 and mtime increments by 1, else counter increments.
REQ-015 DIV=0 SHALL increment mtime on every qualifying tick event; DIV=D SHALL increment once per D+1 qualifying events.
REQ-016 Any write to CTRL SHALL clear the prescale counter to 0 on the same edge, overriding REQ-014.
REQ-017 mtime SHALL be 64 bits and wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-018 When a write to MTIME or MTIMEH coincides with an increment, the written word SHALL take pwdata and the other word SHALL take its incremented value.
REQ-019 Writes to MTIMECMP[i]/MTIMECMPH[i] SHALL update only that 32-bit word; no write buffering or atomic 64-bit staging.
REQ-020 timer_irq[i] SHALL be registered as (mtime >= mtimecmp[i]) unsigned 64-bit, evaluated on current register values, i.e. 1 clk latency after any mtime or mtimecmp change.
REQ-021 timer_irq[i] SHALL deassert 1 clk after a write making mtimecmp[i] > mtime; there is no sticky or clear-on-read state.
REQ-022 dbg_halt=1 SHALL hold mtime and prescale counter but SHALL NOT block bus writes or IRQ evaluation.

Reset
REQ-023 While rst=1: EN=1, DIV=0, prescale counter=0, mtime=0, all mtimecmp[i]=0xFFFF_FFFF_FFFF_FFFF, timer_irq=0.
REQ-024 Reset assertion mid-count SHALL take effect asynchronously; first increment after release needs a fresh qualifying tick.
REQ-025 pready=1 and pslverr follows REQ-012 combinationally, including during reset.

Verification
REQ-026 Reset, tick=1 for 5 clk, DIV=0 -> MTIME reads 5, MTIMEH 0, timer_irq=0.
REQ-027 Write CTRL=0x0301 (DIV=3, EN=1), tick=1 for 12 clk -> mtime advances by exactly 3; write CTRL=0x0300 -> mtime frozen under further ticks.
REQ-028 N_HARTS=2: MTIMECMP[1]=10, MTIMECMPH[1]=0, ticks to mtime=10 -> timer_irq=2'b10 on the clk after mtime reaches 10; then MTIMECMP[1]=20 -> timer_irq[1]=0 one clk later.
REQ-029 MTIMEH=0xFFFF_FFFF, MTIME=0xFFFF_FFFF, one tick -> mtime=0; simultaneous MTIME write 0x55 with increment from 0x0000_0000_FFFF_FFFF -> mtime=0x0000_0001_0000_0055.
REQ-030 Access 0x110 with N_HARTS=2, and write 0x004 -> pslverr=1, prdata=0, no state change; dbg_halt=1 with ticks -> mtime unchanged.

Source files
------------

// File: rtl/hazard3_aclint_mtimer_if.sv
// ---------------------------------------------------------------------------
// hazard3_aclint_mtimer_if
// APB bus bundle for the machine timer register block.
//   paddr   : 16-bit byte address from the master
//   psel    : slave select
//   penable : high in the access phase of a transfer
//   pwrite  : 1 = write, 0 = read
//   pwdata  : 32-bit write data
//   prdata  : 32-bit read data from the slave
//   pready  : slave ready (this slave never inserts wait states)
//   pslverr : slave error for unmapped or illegal accesses
// ---------------------------------------------------------------------------
interface hazard3_aclint_mtimer_if;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/hazard3_aclint_mtimer.sv
// ---------------------------------------------------------------------------
// hazard3_aclint_mtimer
// ACLINT-style machine timer: a 64-bit mtime counter advanced by a
// prescaled external tick, plus one 64-bit compare register and one
// registered interrupt output per hart. Registers are reached over APB.
//
// Ports
//   clk       : sole clock
//   rst       : asynchronous active-high reset
//   apb       : APB slave (see hazard3_aclint_mtimer_if)
//   dbg_halt  : freezes mtime and the prescaler while high
//   tick      : level tick; each clk edge with tick=1 is one tick event
//   timer_irq : per-hart machine timer interrupt, registered
//
// Register map (byte addresses)
//   0x000 CTRL        bit0 EN, bits[8+DIV_W-1:8] DIV
//   0x004 IRQ_STATUS  read-only copy of timer_irq
//   0x008 MTIME       mtime[31:0]
//   0x00C MTIMEH      mtime[63:32]
//   0x100+8*i         MTIMECMP[i]  low word
//   0x104+8*i         MTIMECMPH[i] high word
// ---------------------------------------------------------------------------
module hazard3_aclint_mtimer #(
  parameter int N_HARTS = 1,
  parameter int DIV_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  hazard3_aclint_mtimer_if.slave     apb,
  input  logic                       dbg_halt,
  input  logic                       tick,
  output logic [N_HARTS-1:0]         timer_irq
);

  // Register state
  logic               ctrlEn_q,       ctrlEn_d;
  logic [DIV_W-1:0]   ctrlDiv_q,      ctrlDiv_d;
  logic [DIV_W-1:0]   prescaleCnt_q,  prescaleCnt_d;
  logic [63:0]        mtime_q,        mtime_d;
  logic [63:0]        mtimecmp_q [N_HARTS];
  logic [63:0]        mtimecmp_d [N_HARTS];
  logic [N_HARTS-1:0] irq_q,          irq_d;

  // Address decode
  logic       access;
  logic       isCtrl, isStatus, isMtime, isMtimeh;
  logic       cmpRegion, cmpValid, cmpHi;
  logic [3:0] cmpIdx;
  logic       addrValid, busErr;
  logic       wrEn;
  logic [63:0] cmpRead;
  logic [31:0] readData;

  // Prescaler
  logic tickQual, incMtime;
  logic [63:0] mtimeInc;

  assign access    = apb.psel && apb.penable;
  assign isCtrl    = (apb.paddr == 16'h0000);
  assign isStatus  = (apb.paddr == 16'h0004);
  assign isMtime   = (apb.paddr == 16'h0008);
  assign isMtimeh  = (apb.paddr == 16'h000C);
  // Comparator window is 0x100..0x17F; slots beyond N_HARTS are unmapped.
  assign cmpRegion = (apb.paddr[15:7] == 9'h002) && (apb.paddr[1:0] == 2'b00);
  assign cmpIdx    = apb.paddr[6:3];
  assign cmpHi     = apb.paddr[2];
  assign cmpValid  = cmpRegion && ({1'b0, cmpIdx} < 5'(N_HARTS));
  assign addrValid = isCtrl || isStatus || isMtime || isMtimeh || cmpValid;
  // IRQ_STATUS is read-only, so a write to it is an error just like a hole.
  assign busErr    = !addrValid || (apb.pwrite && isStatus);
  assign wrEn      = access && apb.pwrite && !busErr;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access && busErr;
  assign apb.prdata  = busErr ? 32'h0 : readData;

  // Comparator read select; only indices below N_HARTS can match.
  always_comb begin
    cmpRead = 64'h0;
    for (int i = 0; i < N_HARTS; i++) begin
      if (cmpIdx == 4'(i)) cmpRead = mtimecmp_q[i];
    end
  end

  always_comb begin
    readData = 32'h0;
    if (isCtrl)        readData = 32'(ctrlEn_q) | (32'(ctrlDiv_q) << 8);
    else if (isStatus) readData = 32'(irq_q);
    else if (isMtime)  readData = mtime_q[31:0];
    else if (isMtimeh) readData = mtime_q[63:32];
    else if (cmpValid) readData = cmpHi ? cmpRead[63:32] : cmpRead[31:0];
  end

  // A tick only counts when enabled and not halted; mtime steps when the
  // prescaler has seen DIV+1 qualifying ticks.
  assign tickQual = tick && ctrlEn_q && !dbg_halt;
  assign incMtime = tickQual && (prescaleCnt_q == ctrlDiv_q);
  assign mtimeInc = incMtime ? mtime_q + 64'd1 : mtime_q;

  always_comb begin
    ctrlEn_d      = ctrlEn_q;
    ctrlDiv_d     = ctrlDiv_q;
    prescaleCnt_d = prescaleCnt_q;
    mtime_d       = mtimeInc;
    for (int i = 0; i < N_HARTS; i++) mtimecmp_d[i] = mtimecmp_q[i];

    if (tickQual) begin
      prescaleCnt_d = incMtime ? '0 : prescaleCnt_q + 1'b1;
    end

    if (wrEn && isCtrl) begin
      ctrlEn_d      = apb.pwdata[0];
      ctrlDiv_d     = apb.pwdata[8 +: DIV_W];
      // A CTRL write restarts the prescale period from zero.
      prescaleCnt_d = '0;
    end

    // A word write merges with the incremented value of the other word.
    if (wrEn && isMtime)  mtime_d[31:0]  = apb.pwdata;
    if (wrEn && isMtimeh) mtime_d[63:32] = apb.pwdata;

    for (int i = 0; i < N_HARTS; i++) begin
      if (wrEn && cmpValid && (cmpIdx == 4'(i))) begin
        if (cmpHi) mtimecmp_d[i][63:32] = apb.pwdata;
        else       mtimecmp_d[i][31:0]  = apb.pwdata;
      end
    end
  end

  // Interrupts compare the current register values, giving one clk latency.
  always_comb begin
    irq_d = '0;
    for (int i = 0; i < N_HARTS; i++) irq_d[i] = (mtime_q >= mtimecmp_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrlEn_q      <= 1'b1;
      ctrlDiv_q     <= '0;
      prescaleCnt_q <= '0;
      mtime_q       <= 64'h0;
      irq_q         <= '0;
      for (int i = 0; i < N_HARTS; i++) mtimecmp_q[i] <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      ctrlEn_q      <= ctrlEn_d;
      ctrlDiv_q     <= ctrlDiv_d;
      prescaleCnt_q <= prescaleCnt_d;
      mtime_q       <= mtime_d;
      irq_q         <= irq_d;
      for (int i = 0; i < N_HARTS; i++) mtimecmp_q[i] <= mtimecmp_d[i];
    end
  end

  assign timer_irq = irq_q;

endmodule

// File: tb/tb_hazard3_aclint_mtimer.sv
// ---------------------------------------------------------------------------
// tb_hazard3_aclint_mtimer
// Directed bench for hazard3_aclint_mtimer with two harts and an 8-bit
// divisor. Inputs change on the falling edge; outputs are sampled away
// from the rising edge.
// ---------------------------------------------------------------------------
module tb_hazard3_aclint_mtimer;

  logic       clk;
  logic       rst;
  logic       dbg_halt;
  logic       tick;
  logic [1:0] timer_irq;

  int compared;
  int mismatched;

  hazard3_aclint_mtimer_if apb ();

  hazard3_aclint_mtimer #(
    .N_HARTS (2),
    .DIV_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .apb       (apb),
    .dbg_halt  (dbg_halt),
    .tick      (tick),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Holds tick high for n rising edges; starts and ends on a falling edge.
  task automatic applyStimulus(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  // Two-phase APB write; tickAcc drives tick during the access edge.
  task automatic apbWrite(input logic [15:0] addr, input logic [31:0] data,
                          input logic tickAcc, output logic err);
    apb.paddr   = addr;
    apb.pwdata  = data;
    apb.pwrite  = 1'b1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    tick        = tickAcc;
    #1 err = apb.pslverr;
    @(negedge clk);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    tick        = 1'b0;
  endtask

  task automatic apbRead(input logic [15:0] addr, output logic [31:0] data,
                         output logic err);
    apb.paddr   = addr;
    apb.pwrite  = 1'b0;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    data = apb.prdata;
    err  = apb.pslverr;
    @(negedge clk);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;

    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    dbg_halt    = 1'b0;
    tick        = 1'b0;
    apb.paddr   = 16'h0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.pwdata  = 32'h0;

    // Reset state, observed while reset is still held
    repeat (2) @(negedge clk);
    checkOutput("reset_irq", 64'(timer_irq), 64'h0);
    checkOutput("reset_pready", 64'(apb.pready), 64'h1);
    apb.paddr = 16'h0000;
    #1 checkOutput("reset_ctrl", 64'(apb.prdata), 64'h1);
    apb.paddr = 16'h0104;
    #1 checkOutput("reset_cmp0h", 64'(apb.prdata), 64'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;

    // DIV=0: five ticks give five increments
    applyStimulus(5);
    apbRead(16'h0008, rd, err);
    checkOutput("div0_mtime", 64'(rd), 64'd5);
    checkOutput("div0_err", 64'(err), 64'h0);
    apbRead(16'h000C, rd, err);
    checkOutput("div0_mtimeh", 64'(rd), 64'd0);
    checkOutput("div0_irq", 64'(timer_irq), 64'h0);

    // DIV=3: twelve ticks give three increments; then disable
    apbWrite(16'h0000, 32'h0000_0301, 1'b0, err);
    applyStimulus(12);
    apbRead(16'h0008, rd, err);
    checkOutput("div3_mtime", 64'(rd), 64'd8);
    apbRead(16'h0000, rd, err);
    checkOutput("div3_ctrl", 64'(rd), 64'h301);
    apbWrite(16'h0000, 32'h0000_0300, 1'b0, err);
    applyStimulus(5);
    apbRead(16'h0008, rd, err);
    checkOutput("disabled_mtime", 64'(rd), 64'd8);

    // Hart 1 compare at 10
    apbWrite(16'h0000, 32'h0000_0001, 1'b0, err);
    apbWrite(16'h0108, 32'd10, 1'b0, err);
    apbWrite(16'h010C, 32'd0, 1'b0, err);
    applyStimulus(2);
    checkOutput("irq_latency", 64'(timer_irq), 64'h0);
    @(negedge clk);
    checkOutput("irq_asserted", 64'(timer_irq), 64'h2);
    apbRead(16'h0004, rd, err);
    checkOutput("irq_status", 64'(rd), 64'h2);
    apbWrite(16'h0108, 32'd20, 1'b0, err);
    checkOutput("irq_hold", 64'(timer_irq), 64'h2);
    @(negedge clk);
    checkOutput("irq_deassert", 64'(timer_irq), 64'h0);

    // 64-bit wrap
    apbWrite(16'h000C, 32'hFFFF_FFFF, 1'b0, err);
    apbWrite(16'h0008, 32'hFFFF_FFFF, 1'b0, err);
    applyStimulus(1);
    apbRead(16'h0008, rd, err);
    checkOutput("wrap_lo", 64'(rd), 64'h0);
    apbRead(16'h000C, rd, err);
    checkOutput("wrap_hi", 64'(rd), 64'h0);

    // Low-word write coinciding with an increment that carries into high
    apbWrite(16'h0008, 32'hFFFF_FFFF, 1'b0, err);
    apbWrite(16'h0008, 32'h0000_0055, 1'b1, err);
    apbRead(16'h0008, rd, err);
    checkOutput("merge_lo", 64'(rd), 64'h55);
    apbRead(16'h000C, rd, err);
    checkOutput("merge_hi", 64'(rd), 64'h1);

    // Illegal accesses
    apbRead(16'h0110, rd, err);
    checkOutput("slot2_rd_err", 64'(err), 64'h1);
    checkOutput("slot2_rd_data", 64'(rd), 64'h0);
    apbWrite(16'h0110, 32'h1234, 1'b0, err);
    checkOutput("slot2_wr_err", 64'(err), 64'h1);
    apbWrite(16'h0004, 32'h0, 1'b0, err);
    checkOutput("status_wr_err", 64'(err), 64'h1);
    apbRead(16'h0200, rd, err);
    checkOutput("hole_err", 64'(err), 64'h1);
    apbRead(16'h0004, rd, err);
    checkOutput("status_rd_err", 64'(err), 64'h0);
    checkOutput("status_rd", 64'(rd), 64'h2);
    apbRead(16'h0100, rd, err);
    checkOutput("cmp0_untouched", 64'(rd), 64'hFFFF_FFFF);
    apbRead(16'h0108, rd, err);
    checkOutput("cmp1_untouched", 64'(rd), 64'd20);

    // Debug halt freezes mtime but not bus writes or IRQ evaluation
    dbg_halt = 1'b1;
    applyStimulus(4);
    apbWrite(16'h0104, 32'h0, 1'b0, err);
    apbWrite(16'h0100, 32'h0, 1'b0, err);
    @(negedge clk);
    checkOutput("halt_irq", 64'(timer_irq), 64'h3);
    apbRead(16'h0008, rd, err);
    checkOutput("halt_mtime", 64'(rd), 64'h55);
    dbg_halt = 1'b0;
    applyStimulus(2);
    apbRead(16'h0008, rd, err);
    checkOutput("resume_mtime", 64'(rd), 64'h57);

    // Asynchronous reset mid prescale count
    apbWrite(16'h0000, 32'h0000_0301, 1'b0, err);
    applyStimulus(2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_irq", 64'(timer_irq), 64'h0);
    apb.paddr = 16'h0008;
    #1 checkOutput("async_mtime", 64'(apb.prdata), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1);
    apbRead(16'h0008, rd, err);
    checkOutput("post_reset_tick", 64'(rd), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
